// File: rtl/shim_trigger_pkg.sv
// rtl/shim_trigger_pkg.sv - shared command-word layout for the shim trigger path
// Opcode values are also consumed by software tooling; renumbering breaks the host side.
package shim_trigger_pkg;

   localparam int CMD_W   = 32;
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 29;

   typedef enum logic [2:0] {
      CANCEL          = 3'd1,
      SYNC_CH         = 3'd2,
      SET_LOCKOUT     = 3'd3,
      EXPECT_EXT_TRIG = 3'd4,
      DELAY           = 3'd5,
      FORCE_TRIG      = 3'd6
   } opcode_e;

   function automatic opcode_e cmd_opcode(input logic [CMD_W-1:0] cmd);
      return opcode_e'(cmd[OPC_MSB:OPC_LSB]);
   endfunction

endpackage

// File: rtl/shim_sdp_ram.sv
// rtl/shim_sdp_ram.sv - simple dual-port RAM with registered read, no reset
// The read register only loads on rd_en so its contents persist between reads.
module shim_sdp_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/shim_trigger_cmd_fifo.sv
// rtl/shim_trigger_cmd_fifo.sv - first-word-fall-through command buffer feeding the trigger core
// The RAM read register is the output stage; mem_count counts only words still inside the RAM.
module shim_trigger_cmd_fifo
   import shim_trigger_pkg::*;
#(
   parameter int DEPTH_LOG2         = 10,
   parameter int ALMOST_FULL_MARGIN = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [CMD_W-1:0]      wr_data,
   output logic                  full,
   output logic                  almost_full,
   output logic [DEPTH_LOG2:0]   word_count,
   input  logic                  cmd_word_rd_en,
   output logic [CMD_W-1:0]      cmd_word,
   output logic                  cmd_buf_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [DEPTH_LOG2:0] CAPACITY = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
   localparam logic [DEPTH_LOG2:0] AF_LEVEL =
      (DEPTH_LOG2+1)'(2**DEPTH_LOG2 - ALMOST_FULL_MARGIN);
   localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   mem_count;
   logic                  out_valid;
   logic                  word_loaded;
   logic [CMD_W-1:0]      ram_q;
   logic                  wr_accept;
   logic                  fetch;

   assign word_count    = mem_count + (DEPTH_LOG2+1)'(out_valid);
   assign full          = (word_count == CAPACITY);
   assign almost_full   = (word_count >= AF_LEVEL);
   assign cmd_buf_empty = !out_valid;

   // The RAM has no reset, so the output reads as zero until the first fetch after reset.
   assign cmd_word = word_loaded ? ram_q : '0;

   assign wr_accept = wr_en && !full && !clear;
   assign fetch     = (mem_count != '0) && (!out_valid || cmd_word_rd_en) && !clear;

   shim_sdp_ram #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (CMD_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (fetch),
      .rd_addr (rd_ptr),
      .rd_data (ram_q)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         mem_count   <= '0;
         out_valid   <= 1'b0;
         word_loaded <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (fetch) begin
            rd_ptr      <= rd_ptr + PTR_ONE;
            out_valid   <= 1'b1;
            word_loaded <= 1'b1;
         end else if (cmd_word_rd_en && out_valid) begin
            out_valid <= 1'b0;
         end
         if (cmd_word_rd_en && !out_valid) begin
            underflow <= 1'b1;
         end
         case ({wr_accept, fetch})
            2'b10:   mem_count <= mem_count + CNT_ONE;
            2'b01:   mem_count <= mem_count - CNT_ONE;
            default: mem_count <= mem_count;
         endcase
      end
   end

endmodule

// File: tb/tb_shim_trigger_cmd_fifo.sv
// tb/tb_shim_trigger_cmd_fifo.sv - directed self-checking bench for shim_trigger_cmd_fifo at depth 16
module tb_shim_trigger_cmd_fifo;

   localparam int DL = 4;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          clear = 1'b0;
   logic          wr_en = 1'b0;
   logic [31:0]   wr_data = '0;
   logic          full;
   logic          almost_full;
   logic [DL:0]   word_count;
   logic          cmd_word_rd_en = 1'b0;
   logic [31:0]   cmd_word;
   logic          cmd_buf_empty;
   logic          overflow;
   logic          underflow;

   int tests = 0;
   int fails = 0;

   shim_trigger_cmd_fifo #(
      .DEPTH_LOG2         (DL),
      .ALMOST_FULL_MARGIN (4)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .clear          (clear),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .full           (full),
      .almost_full    (almost_full),
      .word_count     (word_count),
      .cmd_word_rd_en (cmd_word_rd_en),
      .cmd_word       (cmd_word),
      .cmd_buf_empty  (cmd_buf_empty),
      .overflow       (overflow),
      .underflow      (underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_empty"},  32'(cmd_buf_empty), 32'd1);
      chk({tag, "_word"},   cmd_word,           32'd0);
      chk({tag, "_full"},   32'(full),          32'd0);
      chk({tag, "_af"},     32'(almost_full),   32'd0);
      chk({tag, "_count"},  32'(word_count),    32'd0);
      chk({tag, "_ovf"},    32'(overflow),      32'd0);
      chk({tag, "_unf"},    32'(underflow),     32'd0);
   endtask

   initial begin
      #1;
      check_reset_outputs("reset");
      #13 resetn = 1'b1;
      tick();

      // single word latency
      wr_en = 1'b1; wr_data = 32'h4000_0003;
      tick();
      wr_en = 1'b0;
      chk("single_count_n", 32'(word_count), 32'd1);
      chk("single_empty_n", 32'(cmd_buf_empty), 32'd1);
      tick();
      chk("single_empty_n1", 32'(cmd_buf_empty), 32'd0);
      chk("single_word_n1", cmd_word, 32'h4000_0003);
      cmd_word_rd_en = 1'b1;
      tick();
      cmd_word_rd_en = 1'b0;
      chk("single_empty_rd", 32'(cmd_buf_empty), 32'd1);
      chk("single_count_rd", 32'(word_count), 32'd0);
      chk("single_hold_word", cmd_word, 32'h4000_0003);

      // fill to capacity, thresholds, overflow, ordered drain
      for (int i = 1; i <= 16; i++) begin
         wr_en = 1'b1; wr_data = 32'(i);
         tick();
         chk($sformatf("fill_count_%0d", i), 32'(word_count), 32'(i));
         chk($sformatf("fill_af_%0d", i),    32'(almost_full), (i >= 12) ? 32'd1 : 32'd0);
         chk($sformatf("fill_full_%0d", i),  32'(full),        (i == 16) ? 32'd1 : 32'd0);
      end
      wr_data = 32'd99;
      tick();
      wr_en = 1'b0;
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(word_count), 32'd16);
      chk("ovf_full", 32'(full), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         chk($sformatf("drain_empty_%0d", i), 32'(cmd_buf_empty), 32'd0);
         chk($sformatf("drain_word_%0d", i),  cmd_word, 32'(i));
         cmd_word_rd_en = 1'b1;
         tick();
      end
      cmd_word_rd_en = 1'b0;
      chk("drain_done_empty", 32'(cmd_buf_empty), 32'd1);
      chk("drain_done_count", 32'(word_count), 32'd0);
      chk("drain_ovf_sticky", 32'(overflow), 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_ovf", 32'(overflow), 32'd0);

      // streaming across pointer wrap
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = 32'(1000 + i);
         tick();
      end
      wr_en = 1'b0;
      tick();
      chk("stream_pre_count", 32'(word_count), 32'd3);
      for (int i = 0; i < 100; i++) begin
         chk($sformatf("stream_empty_%0d", i), 32'(cmd_buf_empty), 32'd0);
         chk($sformatf("stream_word_%0d", i),  cmd_word, 32'(1000 + i));
         wr_en = 1'b1; wr_data = 32'(1003 + i);
         cmd_word_rd_en = 1'b1;
         tick();
         chk($sformatf("stream_count_%0d", i), 32'(word_count), 32'd3);
      end
      wr_en = 1'b0; cmd_word_rd_en = 1'b0;
      chk("stream_tail_word", cmd_word, 32'd1100);
      clear = 1'b1;
      tick();
      clear = 1'b0;

      // underflow
      cmd_word_rd_en = 1'b1;
      tick();
      cmd_word_rd_en = 1'b0;
      chk("unf_flag", 32'(underflow), 32'd1);
      chk("unf_empty", 32'(cmd_buf_empty), 32'd1);
      chk("unf_count", 32'(word_count), 32'd0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("unf_cleared", 32'(underflow), 32'd0);

      // clear beats simultaneous write and read
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 32'(200 + i);
         tick();
      end
      wr_en = 1'b0;
      tick();
      chk("clr_pre_count", 32'(word_count), 32'd5);
      clear = 1'b1; wr_en = 1'b1; wr_data = 32'hDEAD_BEEF; cmd_word_rd_en = 1'b1;
      tick();
      clear = 1'b0; wr_en = 1'b0; cmd_word_rd_en = 1'b0;
      chk("clr_empty", 32'(cmd_buf_empty), 32'd1);
      chk("clr_count", 32'(word_count), 32'd0);
      tick();
      tick();
      chk("clr_write_dropped_count", 32'(word_count), 32'd0);
      chk("clr_write_dropped_empty", 32'(cmd_buf_empty), 32'd1);

      // asynchronous reset mid-operation
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 32'(300 + i);
         tick();
      end
      wr_en = 1'b0;
      tick();
      chk("arst_pre_count", 32'(word_count), 32'd5);
      chk("arst_pre_word", cmd_word, 32'd300);
      #2 resetn = 1'b0;
      #1;
      check_reset_outputs("arst");
      #4 resetn = 1'b1;
      tick();
      check_reset_outputs("arst_after");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shim_trigger_cmd_fifo.md
# shim_trigger_cmd_fifo

First-word-fall-through command buffer directly upstream of the shim trigger core. It accepts 32-bit trigger command words from the PS/AXI write side and presents the oldest word combinationally on `cmd_word` with `cmd_buf_empty`, which is the interface the trigger core consumes. It tracks occupancy, raises full and almost-full back-pressure, and records sticky overflow/underflow errors for the status register.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: log2 of capacity; capacity is 2**DEPTH_LOG2 words.
- `ALMOST_FULL_MARGIN`, 4: `almost_full` asserts when free space is ≤ this value (1 … 2**DEPTH_LOG2-1).

Ports:
- `clk`  in  1  single clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush of contents and sticky flags.
- `wr_en`  in  1  write strobe.
- `wr_data`  in  32  command word to enqueue.
- `full`  out  1  no space; writes are dropped.
- `almost_full`  out  1  occupancy ≥ 2**DEPTH_LOG2 − ALMOST_FULL_MARGIN.
- `word_count`  out  DEPTH_LOG2+1  words held, including the word at the output.
- `cmd_word_rd_en`  in  1  consume the word on `cmd_word`.
- `cmd_word`  out  32  oldest word, valid while `cmd_buf_empty` is low.
- `cmd_buf_empty`  out  1  no word presented.
- `overflow`  out  1  sticky: a write was attempted while full.
- `underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- Storage: simple dual-port RAM of 2**DEPTH_LOG2 × 32 with a registered read. The RAM read register is the output stage, and `out_valid` = !`cmd_buf_empty`.
- `mem_count` counts words in the RAM that are not yet in the output stage. `word_count` = `mem_count` + `out_valid`.
- Write is accepted when `wr_en && !full`. The RAM is written at `wr_ptr`, `wr_ptr` increments, and `mem_count` increments.
- Rejected write (`wr_en && full`): data is dropped, `overflow` is set to 1, and no other state changes.
- Fetch is issued when `mem_count != 0 && (!out_valid || cmd_word_rd_en)`. It reads `rd_ptr`, increments `rd_ptr`, and decrements `mem_count`. `out_valid` is 1 at the next edge.
- Consume without fetch (`cmd_word_rd_en && out_valid && mem_count == 0`): `out_valid` becomes 0 at the next edge.
- `cmd_word_rd_en && !out_valid`: ignored and `underflow` is set to 1.
- Fetch never uses a word written in the same cycle, because `mem_count` excludes it. No read-during-write hazard exists.
- Pointers are DEPTH_LOG2 bits wide and wrap naturally modulo 2**DEPTH_LOG2.
- `full` = (`word_count` == 2**DEPTH_LOG2). A write in the same cycle as a read while full is still rejected, because `full` is registered-state-derived.
- `clear` has priority over `wr_en` and `cmd_word_rd_en` in that cycle. It zeroes the pointers, `mem_count`, `out_valid`, `overflow` and `underflow`.
- `cmd_word` holds its last value when empty. It is not zeroed except by reset.

## Timing
- Reset values: `cmd_buf_empty`=1, `cmd_word`=0, `full`=0, `almost_full`=0, `word_count`=0, `overflow`=0, `underflow`=0. RAM contents are not reset and are unreachable after reset.
- Reset asserted mid-operation: all registers clear immediately (asynchronously), and in-flight words are lost.
- `word_count`, `full` and `almost_full` update at the same edge that accepts the write or read.
- Write to an empty FIFO at edge N: the fetch is issued in the following cycle, `cmd_word` is valid and `cmd_buf_empty`=0 after edge N+1.
- Sustained throughput: one write and one read per cycle. A back-to-back `cmd_word_rd_en` with `mem_count` > 0 presents a new word every cycle.
- Consume at edge M with an empty RAM: `cmd_buf_empty`=1 after edge M.
- `cmd_word_rd_en` is only legal while `cmd_buf_empty`=0. The consumer may drive it combinationally from `cmd_word`.

## Structure
- `shim_trigger_pkg` holds:
  - the command-word width (32);
  - opcode field position [31:29] and opcode constants (CANCEL=1, SYNC_CH=2, SET_LOCKOUT=3, EXPECT_EXT_TRIG=4, DELAY=5, FORCE_TRIG=6), shared with the trigger core and software-facing tooling.
- One sub-module, `shim_sdp_ram`, is a parameterized simple dual-port RAM with a registered read. It has no reset, and the FIFO control logic stays in this block.

## Test plan
- Reset, write 0x40000003 at edge N → `cmd_buf_empty`=0 and `cmd_word`=0x40000003 after N+1, `word_count`=1 after N. Read → empty, `word_count`=0.
- With DEPTH_LOG2=4, ALMOST_FULL_MARGIN=4, write 16 words with no reads:
  - `almost_full` is set at count 12 and `full` at count 16.
  - A 17th write sets `overflow` and leaves count at 16.
  - Draining yields words 1–16 in order.
- Continuous simultaneous write/read for 100 cycles across pointer wrap (DEPTH_LOG2=4) → in-order data, one word per cycle, `word_count` constant.
- `cmd_word_rd_en` while empty → `underflow`=1, state unchanged. A following `clear` → `underflow`=0.
- Load 5 words, assert `clear` together with `wr_en` and `cmd_word_rd_en` → empty, `word_count`=0, and the write is discarded.
- Load 5 words, pulse `resetn` low asynchronously between edges → all outputs return to their reset values immediately, without waiting for a clock edge.
